// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: D bits per cycle, LSD first, with signed
// overflow, unsigned carry/borrow and zero flags behind a Start/Ready/Done handshake.
module serial_add_sub #(
  parameter int unsigned L = 16,
  parameter int unsigned D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Sub,
  input  logic [L-1:0] A,
  input  logic [L-1:0] B,
  output logic         Ready,
  output logic         Done,
  output logic [L-1:0] S,
  output logic         Overflow,
  output logic         Carry,
  output logic         Zero
);

  localparam int unsigned N  = L / D;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [L-1:0]  a_q, b_q, r_q;
  logic          c_q;
  logic [CW-1:0] cnt_q;

  logic [D:0]    dsum_c;
  logic          last_c;
  logic          cmsb_c;
  logic [L-1:0]  a_shift_c, b_shift_c, res_c;
  logic          hi_zero_c;

  // One D-bit digit add per cycle; the carry register closes the loop.
  assign dsum_c = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, c_q};
  assign last_c = (cnt_q == CW'(N - 1));
  // Carry into the top bit of the current digit, i.e. into the word MSB on the last digit.
  assign cmsb_c = a_q[D-1] ^ b_q[D-1] ^ dsum_c[D-1];

  generate
    if (D == L) begin : g_full
      assign a_shift_c = '0;
      assign b_shift_c = '0;
      assign res_c     = dsum_c[D-1:0];
      assign hi_zero_c = 1'b1;
    end else begin : g_part
      assign a_shift_c = {{D{1'b0}}, a_q[L-1:D]};
      assign b_shift_c = {{D{1'b0}}, b_q[L-1:D]};
      assign res_c     = {dsum_c[D-1:0], r_q[L-1:D]};
      // Upper digits are already registered; only the final digit is fresh.
      assign hi_zero_c = (r_q[L-1:D] == '0);
    end
  endgenerate

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (Start)  state_n = RUN;
      RUN:     if (last_c) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the upcoming state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ready <= 1'b1;
      Done  <= 1'b0;
    end else begin
      Ready <= (state_n == IDLE);
      Done  <= (state_n == DONE);
    end
  end

  // Operand/result shift registers and result flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      S        <= '0;
      Overflow <= 1'b0;
      Carry    <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B ^ {L{Sub}};
            c_q   <= Sub;
            r_q   <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_shift_c;
          b_q   <= b_shift_c;
          c_q   <= dsum_c[D];
          r_q   <= res_c;
          cnt_q <= cnt_q + CW'(1);
          if (last_c) begin
            S        <= res_c;
            Carry    <= dsum_c[D];
            Overflow <= cmsb_c ^ dsum_c[D];
            Zero     <= hi_zero_c && (dsum_c[D-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
